pma_rule_unit: RTL

Runtime-programmable physical-memory-attribute checker for the CVA6 memory subsystem. It holds a table of NrRules address regions, and each region carries an attribute vector (non-idempotent, execute, cacheable, shared). It serves NrPorts independent lookup channels (fetch, load/store, PTW) through registered valid/ready pipelines. Compared with the static per-class region lists in the core configuration, it adds a merged, priority-ordered table, write/lock programming at run time, and multiple concurrent lookup ports.

---
 rtl/pma_pkg.sv | 28 ++
 rtl/pma_rule_match.sv | 31 +++
 rtl/pma_rule_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pma_pkg.sv
// Shared types and the region match rule for the PMA rule checker.
// Region ends are computed on 65 bits so a region may end exactly at 2^64.
package pma_pkg;

  localparam int unsigned NrMaxRules = 64;

  typedef struct packed {
    logic shared;
    logic cacheable;
    logic execute;
    logic non_idempotent;
  } pma_attr_t;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] len;
    pma_attr_t   attr;
    logic        en;
    logic        lock;
  } pma_rule_t;

  function automatic logic pma_match(input pma_rule_t rule, input logic [63:0] addr);
    logic [64:0] lim;
    lim = {1'b0, rule.base} + {1'b0, rule.len};
    return rule.en && (rule.len != '0) && (addr >= rule.base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/pma_rule_match.sv
// Combinational lookup of one address against the whole rule table.
// When several rules match, the lowest index wins.
module pma_rule_match
  import pma_pkg::*;
#(
  parameter int unsigned NrRules     = 16,
  parameter int unsigned IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1,
  parameter pma_attr_t   DefaultAttr = '0
) (
  input  pma_rule_t [NrRules-1:0] rules_i,
  input  logic [63:0]             addr_i,
  output logic                    hit_o,
  output logic [IdxW-1:0]         idx_o,
  output pma_attr_t               attr_o
);

  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    attr_o = DefaultAttr;
    // Walk from the top so the lowest matching index is assigned last.
    for (int k = int'(NrRules) - 1; k >= 0; k--) begin
      if (pma_match(rules_i[k], addr_i)) begin
        hit_o  = 1'b1;
        idx_o  = IdxW'(k);
        attr_o = rules_i[k].attr;
      end
    end
  end

endmodule

// File: rtl/pma_rule_unit.sv
// Programmable PMA table with lockable entries and NrPorts independent
// one-entry lookup pipelines.
module pma_rule_unit
  import pma_pkg::*;
#(
  parameter int unsigned          NrRules     = 16,
  parameter int unsigned          NrPorts     = 2,
  parameter int unsigned          AddrWidth   = 64,
  parameter pma_rule_t [NrRules-1:0] RstRules = '0,
  parameter pma_attr_t            DefaultAttr = 4'b0000,
  parameter int unsigned          IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NrPorts-1:0]                req_valid_i,
  output logic [NrPorts-1:0]                req_ready_o,
  input  logic [NrPorts-1:0][AddrWidth-1:0] req_addr_i,
  output logic [NrPorts-1:0]                rsp_valid_o,
  input  logic [NrPorts-1:0]                rsp_ready_i,
  output logic [NrPorts-1:0]                rsp_hit_o,
  output logic [NrPorts-1:0][IdxW-1:0]      rsp_idx_o,
  output logic [NrPorts-1:0][3:0]           rsp_attr_o,
  input  logic                              cfg_we_i,
  input  logic                              cfg_re_i,
  input  logic [IdxW-1:0]                   cfg_idx_i,
  input  pma_rule_t                         cfg_wrule_i,
  output pma_rule_t                         cfg_rrule_o,
  output logic                              cfg_rvalid_o,
  output logic                              cfg_err_o
);

  if (NrRules > NrMaxRules || NrRules < 1) begin : gen_bad_rules
    $error("NrRules must be in 1..NrMaxRules");
  end
  if (NrPorts < 1 || NrPorts > 4) begin : gen_bad_ports
    $error("NrPorts must be in 1..4");
  end
  if (AddrWidth > 64) begin : gen_bad_addr
    $error("AddrWidth must not exceed 64");
  end

  pma_rule_t [NrRules-1:0] rules_q, rules_d;
  pma_rule_t               rrule_q, rrule_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic                    idx_ok;

  assign idx_ok = 32'(cfg_idx_i) < NrRules;

  // Reads and lookups see rules_q, i.e. the table before a same-cycle write.
  always_comb begin
    rules_d  = rules_q;
    err_d    = 1'b0;
    rvalid_d = cfg_re_i;
    rrule_d  = rrule_q;
    if (cfg_we_i) begin
      if (idx_ok && !rules_q[cfg_idx_i].lock) begin
        rules_d[cfg_idx_i] = cfg_wrule_i;
      end else begin
        err_d = 1'b1;
      end
    end
    if (cfg_re_i) begin
      rrule_d = idx_ok ? rules_q[cfg_idx_i] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rules_q  <= RstRules;
      rrule_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rules_q  <= rules_d;
      rrule_q  <= rrule_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign cfg_rrule_o  = rrule_q;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = err_q;

  for (genvar p = 0; p < NrPorts; p++) begin : gen_port
    logic            valid_q, hit_q, hit_d, accept;
    logic [IdxW-1:0] idx_q, idx_d;
    pma_attr_t       attr_q, attr_d;

    pma_rule_match #(
      .NrRules     (NrRules),
      .IdxW        (IdxW),
      .DefaultAttr (DefaultAttr)
    ) u_match (
      .rules_i (rules_q),
      .addr_i  (64'(req_addr_i[p])),
      .hit_o   (hit_d),
      .idx_o   (idx_d),
      .attr_o  (attr_d)
    );

    assign req_ready_o[p] = !valid_q || rsp_ready_i[p];
    assign accept         = req_valid_i[p] && req_ready_o[p];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        hit_q   <= 1'b0;
        idx_q   <= '0;
        attr_q  <= DefaultAttr;
      end else if (accept) begin
        valid_q <= 1'b1;
        hit_q   <= hit_d;
        idx_q   <= idx_d;
        attr_q  <= attr_d;
      end else if (rsp_ready_i[p]) begin
        valid_q <= 1'b0;
      end
    end

    assign rsp_valid_o[p] = valid_q;
    assign rsp_hit_o[p]   = hit_q;
    assign rsp_idx_o[p]   = idx_q;
    assign rsp_attr_o[p]  = attr_q;
  end

endmodule
